pipe_ctrl: RTL and testbench
============================

// Module: pipe_ctrl
// PURPOSE
//  Hazard and sequencing controller for the five pipeline registers (F/D/E/M/W).
//  Generates each stage's stall/bubble from D/E/M/W fields: load-use, ret, mispredict, exception.
//  Adds a data-memory wait handshake, a halt/exception FSM and a wait timeout.
//  Stall/bubble outputs are combinational from inputs and state; state and counters are registered.
// PARAMETERS
//  MEM_TIMEOUT  default 255   max consecutive wait cycles before fault; 0 = no timeout
//  CNT_W        default 32    width of performance counters
// PORTS
//  clk_i          in   1            clock, all state on posedge
//  rst_i          in   1            synchronous reset, active-high
//  D_icode_i      in   `ICODE_BUS   decode-stage icode
//  d_srcA_i       in   `REG_ADDR_BUS decode srcA
//  d_srcB_i       in   `REG_ADDR_BUS decode srcB
//  E_icode_i      in   `ICODE_BUS   execute-stage icode
//  E_dstM_i       in   `REG_ADDR_BUS execute dstM
//  e_Cnd_i        in   1            branch condition from execute
//  M_icode_i      in   `ICODE_BUS   memory-stage icode
//  m_stat_i       in   `STAT_BUS    memory-stage status (post-access)
//  W_stat_i       in   `STAT_BUS    write-back status
//  W_icode_i      in   `ICODE_BUS   write-back icode (counting)
//  mem_req_i      in   1            data memory access in progress this cycle
//  mem_ready_i    in   1            data memory completes this cycle
//  F_stall_o, D_stall_o, M_stall_o, W_stall_o  out 1 each  hold stage register
//  D_bubble_o, E_bubble_o, M_bubble_o          out 1 each  load NOP into stage
//  set_cc_en_o    out  1            condition-code update enable
//  cpu_halt_o     out  1            pipeline stopped (HALT state)
//  mem_fault_o    out  1            halt caused by memory timeout (sticky)
//  cycle_cnt_o, instr_cnt_o, stall_cnt_o  out CNT_W  perf counters (see CONFIGURATION)
// BEHAVIOUR
//  - rst_i=1: state<=RUN; wait_cnt, mem_fault, counters <=0. While rst_i=1: all stalls 0;
//    D/E/M_bubble 1; set_cc_en 0; cpu_halt 0. Reset mid-wait/halt returns to RUN next cycle.
//  - Hazard terms (RUN only):
//    loaduse = E_icode in {`IMRMOVQ,`IPOPQ} && E_dstM!=`NREG && E_dstM in {d_srcA,d_srcB}
//    ret     = `IRET in {D_icode,E_icode,M_icode};  mispred = E_icode==`IJXX && !e_Cnd
//    exc_m   = m_stat!=`SAOK;  exc_w = W_stat!=`SAOK
//  - RUN outputs: F_stall=loaduse|ret; D_stall=loaduse; D_bubble=mispred|(ret&!loaduse);
//    E_bubble=mispred|loaduse; M_bubble=exc_m|exc_w; W_stall=exc_w; M_stall=0;
//    set_cc_en = E_icode==`IOPQ && !exc_m && !exc_w.
//  - FSM states RUN, MEMWAIT, HALT:
//    RUN->MEMWAIT when mem_req_i && !mem_ready_i && !exc_w; MEMWAIT->RUN when mem_ready_i.
//    MEMWAIT outputs: F/D/M/W_stall=1, E_bubble=1, others 0, set_cc_en=0 (whole pipe frozen, no
//    double ALU execution); wait_cnt++ each cycle.
//    MEMWAIT->HALT, mem_fault<=1 when wait_cnt reaches MEM_TIMEOUT (MEM_TIMEOUT!=0) and !mem_ready_i.
//    mem_ready_i in same cycle as timeout wins: ->RUN, no fault. wait_cnt clears on leaving MEMWAIT.
//    RUN->HALT when exc_w (W_stat non-AOK incl. `SHLT); exc_w has priority over mem_req.
//  - HALT: cpu_halt=1; all stalls 1; bubbles 0; set_cc_en 0; exits only via rst_i.
//  - Simultaneous loaduse+mispred: mispred bubbles D, loaduse stalls F and bubbles E (stall D
//    suppressed by bubble: D_bubble has priority in the stage register).
// CONFIGURATION
//  PIPE_PERF_CNT_EN defined: cycle_cnt++ every non-reset cycle not in HALT; instr_cnt++ when
//    W_icode!=`INOP && W_stall=0 && state==RUN; stall_cnt++ when F_stall=1 and state!=HALT.
//    All wrap modulo 2^CNT_W.
//  Not defined: counter logic absent, *_cnt_o tied to 0.
// TESTING
//  E=MRMOVQ dstM=3, d_srcA=3 -> F_stall=1,D_stall=1,E_bubble=1,D_bubble=0 for exactly 1 cycle
//  E=JXX, e_Cnd=0, D=IRET -> D_bubble=1,E_bubble=1,F_stall=1,D_stall=0
//  mem_req=1, mem_ready low 3 cycles -> MEMWAIT 3 cycles, all stalls 1; ready -> RUN next cycle
//  MEM_TIMEOUT=4, ready never -> after 4 wait cycles cpu_halt=1, mem_fault=1; rst_i clears both
//  W_stat=`SHLT -> W_stall=1,M_bubble=1 same cycle; next cycle cpu_halt=1, set_cc_en=0
//  PIPE_PERF_CNT_EN: 10 RUN cycles, 6 non-NOP W retirements -> cycle_cnt=10, instr_cnt=6

Source files
------------

// File: rtl/pipe_ctrl_if.sv
// rtl/pipe_ctrl_if.sv - hazard-controller bundle: pipeline fields in, stage controls and counters out
// pipeline side uses master, controller uses slave

`ifndef PIPE_CTRL_DEFS
`define PIPE_CTRL_DEFS
`define ICODE_BUS    3:0
`define REG_ADDR_BUS 3:0
`define STAT_BUS     2:0
`define INOP         4'h1
`define IMRMOVQ      4'h5
`define IOPQ         4'h6
`define IJXX         4'h7
`define IRET         4'h9
`define IPOPQ        4'hB
`define NREG         4'hF
`define SAOK         3'd1
`define SHLT         3'd4
`endif

interface pipe_ctrl_if #(parameter int CNT_W = 32);
  logic [`ICODE_BUS]    D_icode_i;
  logic [`REG_ADDR_BUS] d_srcA_i;
  logic [`REG_ADDR_BUS] d_srcB_i;
  logic [`ICODE_BUS]    E_icode_i;
  logic [`REG_ADDR_BUS] E_dstM_i;
  logic                 e_Cnd_i;
  logic [`ICODE_BUS]    M_icode_i;
  logic [`STAT_BUS]     m_stat_i;
  logic [`STAT_BUS]     W_stat_i;
  logic [`ICODE_BUS]    W_icode_i;
  logic                 mem_req_i;
  logic                 mem_ready_i;

  logic F_stall_o, D_stall_o, M_stall_o, W_stall_o;
  logic D_bubble_o, E_bubble_o, M_bubble_o;
  logic set_cc_en_o, cpu_halt_o, mem_fault_o;
  logic [CNT_W-1:0] cycle_cnt_o, instr_cnt_o, stall_cnt_o;

  modport master (
    output D_icode_i, d_srcA_i, d_srcB_i, E_icode_i, E_dstM_i, e_Cnd_i,
           M_icode_i, m_stat_i, W_stat_i, W_icode_i, mem_req_i, mem_ready_i,
    input  F_stall_o, D_stall_o, M_stall_o, W_stall_o, D_bubble_o, E_bubble_o,
           M_bubble_o, set_cc_en_o, cpu_halt_o, mem_fault_o,
           cycle_cnt_o, instr_cnt_o, stall_cnt_o
  );

  modport slave (
    input  D_icode_i, d_srcA_i, d_srcB_i, E_icode_i, E_dstM_i, e_Cnd_i,
           M_icode_i, m_stat_i, W_stat_i, W_icode_i, mem_req_i, mem_ready_i,
    output F_stall_o, D_stall_o, M_stall_o, W_stall_o, D_bubble_o, E_bubble_o,
           M_bubble_o, set_cc_en_o, cpu_halt_o, mem_fault_o,
           cycle_cnt_o, instr_cnt_o, stall_cnt_o
  );
endinterface

// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - five-stage hazard/sequencing controller with memory-wait and halt FSM
// Optional performance counters are built when PIPE_PERF_CNT_EN is defined.

`ifndef PIPE_CTRL_DEFS
`define PIPE_CTRL_DEFS
`define ICODE_BUS    3:0
`define REG_ADDR_BUS 3:0
`define STAT_BUS     2:0
`define INOP         4'h1
`define IMRMOVQ      4'h5
`define IOPQ         4'h6
`define IJXX         4'h7
`define IRET         4'h9
`define IPOPQ        4'hB
`define NREG         4'hF
`define SAOK         3'd1
`define SHLT         3'd4
`endif

module pipe_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 255,
  parameter int          CNT_W       = 32
) (
  input logic        clk_i,
  input logic        rst_i,
  pipe_ctrl_if.slave p
);

  localparam int WC_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [1:0] {S_RUN, S_MEMWAIT, S_HALT} state_e;

  state_e          state_q;
  logic [WC_W-1:0] wait_cnt_q;
  logic            mem_fault_q;

  logic loaduse, ret, mispred, exc_m, exc_w;
  logic [31:0] wait_next;
  logic timeout_hit;

  logic f_stall, d_stall, m_stall, w_stall;
  logic d_bubble, e_bubble, m_bubble, set_cc_en, cpu_halt;

  assign loaduse = ((p.E_icode_i == `IMRMOVQ) || (p.E_icode_i == `IPOPQ)) &&
                   (p.E_dstM_i != `NREG) &&
                   ((p.E_dstM_i == p.d_srcA_i) || (p.E_dstM_i == p.d_srcB_i));
  assign ret     = (p.D_icode_i == `IRET) || (p.E_icode_i == `IRET) || (p.M_icode_i == `IRET);
  assign mispred = (p.E_icode_i == `IJXX) && !p.e_Cnd_i;
  assign exc_m   = (p.m_stat_i != `SAOK);
  assign exc_w   = (p.W_stat_i != `SAOK);

  assign wait_next   = 32'(wait_cnt_q) + 32'd1;
  assign timeout_hit = (MEM_TIMEOUT != 0) && (wait_next >= MEM_TIMEOUT);

  // Stage controls; D_bubble wins over D_stall inside the stage register.
  always_comb begin
    f_stall   = 1'b0;
    d_stall   = 1'b0;
    m_stall   = 1'b0;
    w_stall   = 1'b0;
    d_bubble  = 1'b0;
    e_bubble  = 1'b0;
    m_bubble  = 1'b0;
    set_cc_en = 1'b0;
    cpu_halt  = 1'b0;
    if (rst_i) begin
      d_bubble = 1'b1;
      e_bubble = 1'b1;
      m_bubble = 1'b1;
    end else begin
      case (state_q)
        S_RUN: begin
          f_stall   = loaduse | ret;
          d_stall   = loaduse;
          d_bubble  = mispred | (ret & ~loaduse);
          e_bubble  = mispred | loaduse;
          m_bubble  = exc_m | exc_w;
          w_stall   = exc_w;
          set_cc_en = (p.E_icode_i == `IOPQ) && !exc_m && !exc_w;
        end
        S_MEMWAIT: begin
          // Freeze everything; bubbling E keeps the ALU op from executing twice.
          f_stall  = 1'b1;
          d_stall  = 1'b1;
          m_stall  = 1'b1;
          w_stall  = 1'b1;
          e_bubble = 1'b1;
        end
        default: begin
          f_stall  = 1'b1;
          d_stall  = 1'b1;
          m_stall  = 1'b1;
          w_stall  = 1'b1;
          cpu_halt = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_RUN;
      wait_cnt_q  <= '0;
      mem_fault_q <= 1'b0;
    end else begin
      case (state_q)
        S_RUN: begin
          if (exc_w)
            state_q <= S_HALT;
          else if (p.mem_req_i && !p.mem_ready_i)
            state_q <= S_MEMWAIT;
        end
        S_MEMWAIT: begin
          if (p.mem_ready_i) begin
            state_q    <= S_RUN;
            wait_cnt_q <= '0;
          end else if (timeout_hit) begin
            state_q     <= S_HALT;
            mem_fault_q <= 1'b1;
            wait_cnt_q  <= '0;
          end else if (MEM_TIMEOUT != 0) begin
            wait_cnt_q <= wait_cnt_q + WC_W'(1);
          end
        end
        S_HALT: ;
        default: state_q <= S_RUN;
      endcase
    end
  end

  assign p.F_stall_o   = f_stall;
  assign p.D_stall_o   = d_stall;
  assign p.M_stall_o   = m_stall;
  assign p.W_stall_o   = w_stall;
  assign p.D_bubble_o  = d_bubble;
  assign p.E_bubble_o  = e_bubble;
  assign p.M_bubble_o  = m_bubble;
  assign p.set_cc_en_o = set_cc_en;
  assign p.cpu_halt_o  = cpu_halt;
  assign p.mem_fault_o = mem_fault_q;

`ifdef PIPE_PERF_CNT_EN
  logic [CNT_W-1:0] cycle_cnt_q, instr_cnt_q, stall_cnt_q;
  logic [CNT_W-1:0] cycle_cnt_d, instr_cnt_d, stall_cnt_d;

  always_comb begin
    cycle_cnt_d = cycle_cnt_q;
    instr_cnt_d = instr_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (state_q != S_HALT)
      cycle_cnt_d = cycle_cnt_q + CNT_W'(1);
    if ((p.W_icode_i != `INOP) && !w_stall && (state_q == S_RUN))
      instr_cnt_d = instr_cnt_q + CNT_W'(1);
    if (f_stall && (state_q != S_HALT))
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cycle_cnt_q <= '0;
      instr_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      cycle_cnt_q <= cycle_cnt_d;
      instr_cnt_q <= instr_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign p.cycle_cnt_o = cycle_cnt_q;
  assign p.instr_cnt_o = instr_cnt_q;
  assign p.stall_cnt_o = stall_cnt_q;
`else
  logic unused_w_icode;
  assign unused_w_icode = ^p.W_icode_i;
  assign p.cycle_cnt_o  = '0;
  assign p.instr_cnt_o  = '0;
  assign p.stall_cnt_o  = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb/tb_pipe_ctrl.sv - directed self-checking bench for pipe_ctrl (MEM_TIMEOUT=4)

module tb_pipe_ctrl;

  localparam logic [3:0] C_INOP = 4'h1, C_MRMOVQ = 4'h5, C_OPQ = 4'h6, C_JXX = 4'h7;
  localparam logic [3:0] C_RET = 4'h9, C_POPQ = 4'hB, C_NREG = 4'hF;
  localparam logic [2:0] C_AOK = 3'd1, C_ADR = 3'd2, C_HLT = 3'd4;

  // {F_st, D_st, M_st, W_st, D_bub, E_bub, M_bub, set_cc, halt, fault}
  localparam logic [9:0] V_RESET   = 10'b0000111000;
  localparam logic [9:0] V_IDLE    = 10'b0000000000;
  localparam logic [9:0] V_LDUSE   = 10'b1100010000;
  localparam logic [9:0] V_MISRET  = 10'b1000110000;
  localparam logic [9:0] V_RETONLY = 10'b1000100000;
  localparam logic [9:0] V_SETCC   = 10'b0000000100;
  localparam logic [9:0] V_EXCM    = 10'b0000001000;
  localparam logic [9:0] V_FREEZE  = 10'b1111010000;
  localparam logic [9:0] V_HALTF   = 10'b1111000011;
  localparam logic [9:0] V_EXCW    = 10'b0001001000;
  localparam logic [9:0] V_HALT    = 10'b1111000010;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  pipe_ctrl_if #(.CNT_W(32)) bus ();

  pipe_ctrl #(.MEM_TIMEOUT(4), .CNT_W(32)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .p     (bus.slave)
  );

  logic [9:0] ctrl;
  assign ctrl = {bus.F_stall_o, bus.D_stall_o, bus.M_stall_o, bus.W_stall_o,
                 bus.D_bubble_o, bus.E_bubble_o, bus.M_bubble_o,
                 bus.set_cc_en_o, bus.cpu_halt_o, bus.mem_fault_o};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_idle();
    bus.D_icode_i   = C_INOP;
    bus.d_srcA_i    = C_NREG;
    bus.d_srcB_i    = C_NREG;
    bus.E_icode_i   = C_INOP;
    bus.E_dstM_i    = C_NREG;
    bus.e_Cnd_i     = 1'b1;
    bus.M_icode_i   = C_INOP;
    bus.m_stat_i    = C_AOK;
    bus.W_stat_i    = C_AOK;
    bus.W_icode_i   = C_INOP;
    bus.mem_req_i   = 1'b0;
    bus.mem_ready_i = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    set_idle();
    rst = 1'b1;
    tick();
    #1 chk("reset_ctrl", 64'(ctrl), 64'(V_RESET));
    chk("reset_cycle_cnt", 64'(bus.cycle_cnt_o), 64'd0);

    rst = 1'b0;
    #1 chk("idle", 64'(ctrl), 64'(V_IDLE));

    // load-use for one cycle, then E becomes the bubble
    bus.E_icode_i = C_MRMOVQ; bus.E_dstM_i = 4'd3; bus.d_srcA_i = 4'd3;
    #1 chk("loaduse", 64'(ctrl), 64'(V_LDUSE));
    tick();
    set_idle();
    #1 chk("loaduse_gone", 64'(ctrl), 64'(V_IDLE));

    bus.E_icode_i = C_JXX; bus.e_Cnd_i = 1'b0; bus.D_icode_i = C_RET;
    #1 chk("mispred_ret", 64'(ctrl), 64'(V_MISRET));
    set_idle();
    bus.M_icode_i = C_RET;
    #1 chk("ret_in_m", 64'(ctrl), 64'(V_RETONLY));
    set_idle();
    bus.E_icode_i = C_POPQ; bus.E_dstM_i = 4'd2; bus.d_srcB_i = 4'd2; bus.D_icode_i = C_RET;
    #1 chk("loaduse_ret", 64'(ctrl), 64'(V_LDUSE));
    set_idle();
    bus.E_icode_i = C_MRMOVQ;
    #1 chk("nreg_no_hazard", 64'(ctrl), 64'(V_IDLE));
    bus.E_icode_i = C_OPQ;
    #1 chk("set_cc", 64'(ctrl), 64'(V_SETCC));
    bus.m_stat_i = C_ADR;
    #1 chk("exc_m", 64'(ctrl), 64'(V_EXCM));
    tick();
    set_idle();

    // memory wait: three frozen cycles, ready on the third
    bus.mem_req_i = 1'b1;
    #1 chk("memreq_run", 64'(ctrl), 64'(V_IDLE));
    tick();
    #1 chk("memwait1", 64'(ctrl), 64'(V_FREEZE));
    tick();
    bus.E_icode_i = C_OPQ;
    #1 chk("memwait2_nocc", 64'(ctrl), 64'(V_FREEZE));
    tick();
    bus.E_icode_i = C_INOP;
    bus.mem_ready_i = 1'b1;
    #1 chk("memwait3_ready", 64'(ctrl), 64'(V_FREEZE));
    tick();
    set_idle();
    #1 chk("memwait_exit", 64'(ctrl), 64'(V_IDLE));

    // timeout after four wait cycles
    bus.mem_req_i = 1'b1;
    tick();
    tick();
    tick();
    tick();
    #1 chk("memwait4", 64'(ctrl), 64'(V_FREEZE));
    tick();
    #1 chk("timeout_halt", 64'(ctrl), 64'(V_HALTF));
    set_idle();
    tick();
    #1 chk("halt_sticky", 64'(ctrl), 64'(V_HALTF));
    rst = 1'b1;
    tick();
    #1 chk("reset_clears_fault", 64'(ctrl), 64'(V_RESET));
    rst = 1'b0;
    #1 chk("after_reset_idle", 64'(ctrl), 64'(V_IDLE));

    // ready arriving on the timeout cycle wins
    bus.mem_req_i = 1'b1;
    tick();
    tick();
    tick();
    tick();
    bus.mem_ready_i = 1'b1;
    tick();
    set_idle();
    #1 chk("ready_beats_timeout", 64'(ctrl), 64'(V_IDLE));

    // W-stage halt status, with competing memory request and OPQ in E
    bus.W_stat_i = C_HLT; bus.E_icode_i = C_OPQ; bus.mem_req_i = 1'b1;
    #1 chk("exc_w_run", 64'(ctrl), 64'(V_EXCW));
    tick();
    set_idle();
    #1 chk("exc_w_halt", 64'(ctrl), 64'(V_HALT));

    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      bus.W_icode_i = (i % 5 < 3) ? C_OPQ : C_INOP;
      tick();
    end
    set_idle();
`ifdef PIPE_PERF_CNT_EN
    #1 chk("cycle_cnt", 64'(bus.cycle_cnt_o), 64'd10);
    chk("instr_cnt", 64'(bus.instr_cnt_o), 64'd6);
    chk("stall_cnt", 64'(bus.stall_cnt_o), 64'd0);
`else
    #1 chk("cycle_cnt_off", 64'(bus.cycle_cnt_o), 64'd0);
    chk("instr_cnt_off", 64'(bus.instr_cnt_o), 64'd0);
    chk("stall_cnt_off", 64'(bus.stall_cnt_o), 64'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
